// File: rtl/fp16_invsqrt_nr.sv
// fp16 1/sqrt(x) Newton-Raphson refinement: y' = y*(1.5 - (x/2)*y*y), one shared multiplier and adder.
// Optional FP16_INVSQRT_NR_PERF_EN adds perf_count (output handshakes, saturating) and busy.
package fp16_invsqrt_nr_pkg;
   // sig*2^(e-46) -> fp16 with round-to-nearest-even, gradual underflow, overflow to inf
   function automatic logic [15:0] fp16_pack(input logic s, input int e_in, input logic [31:0] sig_in);
      logic [31:0] sig;
      int          e;
      int          lz;
      logic [11:0] mr;
      logic        rnd;
      sig = sig_in;
      e   = e_in;
      lz  = 0;
      for (int i = 0; i < 32; i++) if (sig[i]) lz = 31 - i;
      sig = sig << lz;
      e   = e - lz;
      for (int i = 0; i < 32; i++)
         if (e < 1) begin
            sig = (sig >> 1) | (sig & 32'd1);
            e   = e + 1;
         end
      rnd = sig[20] && ((|sig[19:0]) || sig[21]);
      mr  = {1'b0, sig[31:21]} + {11'd0, rnd};
      if (mr[11]) begin
         mr = mr >> 1;
         e  = e + 1;
      end
      if (sig_in == '0)  fp16_pack = {s, 15'd0};
      else if (e >= 31)  fp16_pack = {s, 5'h1F, 10'd0};
      else               fp16_pack = {s, (mr[10] ? e[4:0] : 5'd0), mr[9:0]};
   endfunction
endpackage

module fp16_mul
   import fp16_invsqrt_nr_pkg::*;
(
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [15:0] y_o
);
   logic        s, a_inf, b_inf, a_nan, b_nan, a_z, b_z;
   logic [21:0] pa;
   int          ea, eb;
   always_comb begin
      s     = a_i[15] ^ b_i[15];
      a_inf = (a_i[14:10] == 5'h1F) && (a_i[9:0] == '0);
      b_inf = (b_i[14:10] == 5'h1F) && (b_i[9:0] == '0);
      a_nan = (a_i[14:10] == 5'h1F) && (a_i[9:0] != '0);
      b_nan = (b_i[14:10] == 5'h1F) && (b_i[9:0] != '0);
      a_z   = a_i[14:0] == '0;
      b_z   = b_i[14:0] == '0;
      ea    = (a_i[14:10] == '0) ? 1 : int'(a_i[14:10]);
      eb    = (b_i[14:10] == '0) ? 1 : int'(b_i[14:10]);
      pa    = 22'({(a_i[14:10] != '0), a_i[9:0]}) * 22'({(b_i[14:10] != '0), b_i[9:0]});
      if (a_nan || b_nan || (a_inf && b_z) || (b_inf && a_z)) y_o = 16'h7E00;
      else if (a_inf || b_inf)                                y_o = {s, 5'h1F, 10'd0};
      else                                                    y_o = fp16_pack(s, ea + eb - 14, {pa, 10'd0});
   end
endmodule

module fp16_add
   import fp16_invsqrt_nr_pkg::*;
(
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [15:0] y_o
);
   logic [15:0] big, sml;
   logic [31:0] sb, ss, sum;
   logic        sub, s;
   int          eb, es;
   always_comb begin
      if (a_i[14:0] >= b_i[14:0]) begin big = a_i; sml = b_i; end
      else                        begin big = b_i; sml = a_i; end
      sub = a_i[15] ^ b_i[15];
      eb  = (big[14:10] == '0) ? 1 : int'(big[14:10]);
      es  = (sml[14:10] == '0) ? 1 : int'(sml[14:10]);
      sb  = {1'b0, (big[14:10] != '0), big[9:0], 20'd0};
      ss  = {1'b0, (sml[14:10] != '0), sml[9:0], 20'd0};
      for (int i = 0; i < 32; i++) if (i < eb - es) ss = (ss >> 1) | (ss & 32'd1);
      sum = sub ? sb - ss : sb + ss;
      // exact cancellation gives +0
      s   = (sub && sum == '0) ? 1'b0 : big[15];
      if (big[14:10] == 5'h1F && (big[9:0] != '0 || (sub && sml[14:0] == big[14:0]))) y_o = 16'h7E00;
      else if (big[14:10] == 5'h1F) y_o = big;
      else                          y_o = fp16_pack(s, eb + 1, sum);
   end
endmodule

module fp16_invsqrt_nr #(
   parameter int ITERATIONS = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_x,
   input  logic [15:0] in_y0,
   input  logic        in_bypass,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_y
`ifdef FP16_INVSQRT_NR_PERF_EN
   ,
   output logic [15:0] perf_count,
   output logic [0:0]  busy
`endif
);
   generate
      if (ITERATIONS < 1 || ITERATIONS > 3) begin : g_bad_iterations
         $error("fp16_invsqrt_nr: ITERATIONS must be 1..3");
      end
   endgenerate

   typedef enum logic [2:0] {S_IDLE, S_XH, S_SQ, S_TERM, S_SUB, S_MUL, S_OUT} state_e;
   state_e      state_q, state_d;
   logic [15:0] x_q, xh_q, y_q, t_q;
   logic [1:0]  cnt_q;
   logic [15:0] mul_a, mul_b, mul_y, add_y;
   logic        accept;

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = in_bypass ? S_OUT : S_XH;
         S_XH:   state_d = S_SQ;
         S_SQ:   state_d = S_TERM;
         S_TERM: state_d = S_SUB;
         S_SUB:  state_d = S_MUL;
         S_MUL:  state_d = (int'(cnt_q) + 1 < ITERATIONS) ? S_SQ : S_OUT;
         S_OUT:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE) && !rst;
      out_valid = state_q == S_OUT;
      out_y     = y_q;
   end

   // operand select for the shared multiplier; MUL state uses the y*t default
   always_comb begin
      mul_a = y_q;
      mul_b = t_q;
      case (state_q)
         S_XH:   begin mul_a = x_q;  mul_b = 16'h3800; end
         S_SQ:   begin mul_a = y_q;  mul_b = y_q;      end
         S_TERM: begin mul_a = xh_q; mul_b = t_q;      end
         default: ;
      endcase
   end

   fp16_mul u_mul (.a_i(mul_a), .b_i(mul_b), .y_o(mul_y));
   fp16_add u_add (.a_i(16'h3E00), .b_i({~t_q[15], t_q[14:0]}), .y_o(add_y));

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q   <= '0;
         xh_q  <= '0;
         y_q   <= '0;
         t_q   <= '0;
         cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (accept) begin x_q <= in_x; y_q <= in_y0; end
            S_XH:   begin xh_q <= mul_y; cnt_q <= '0; end
            S_SQ:   t_q <= mul_y;
            S_TERM: t_q <= mul_y;
            S_SUB:  t_q <= add_y;
            S_MUL:  begin y_q <= mul_y; cnt_q <= cnt_q + 2'd1; end
            default: ;
         endcase
      end
   end

`ifdef FP16_INVSQRT_NR_PERF_EN
   logic [15:0] perf_q;
   always_ff @(posedge clk) begin
      if (rst)                                          perf_q <= '0;
      else if (out_valid && out_ready && perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
   end
   assign perf_count = perf_q;
   assign busy       = 1'(state_q != S_IDLE);
`endif
endmodule

// File: tb/tb_fp16_invsqrt_nr.sv
// Directed bench for fp16_invsqrt_nr: ITERATIONS=1 instance for the main plan, ITERATIONS=2 for the two-pass case.
module tb_fp16_invsqrt_nr;
   logic        clk, rst;
   logic        iv1, ir1, byp1, ov1, ordy1;
   logic [15:0] x1, y01, oy1;
   logic        iv2, ir2, byp2, ov2, ordy2;
   logic [15:0] x2, y02, oy2;
`ifdef FP16_INVSQRT_NR_PERF_EN
   logic [15:0] pc1, pc2;
   logic [0:0]  bz1, bz2;
`endif
   int checks = 0;
   int errors = 0;
   int lat;
   int bad;

   fp16_invsqrt_nr #(.ITERATIONS(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_x(x1), .in_y0(y01),
      .in_bypass(byp1), .out_valid(ov1), .out_ready(ordy1), .out_y(oy1)
`ifdef FP16_INVSQRT_NR_PERF_EN
      , .perf_count(pc1), .busy(bz1)
`endif
   );

   fp16_invsqrt_nr #(.ITERATIONS(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_x(x2), .in_y0(y02),
      .in_bypass(byp2), .out_valid(ov2), .out_ready(ordy2), .out_y(oy2)
`ifdef FP16_INVSQRT_NR_PERF_EN
      , .perf_count(pc2), .busy(bz2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic ov(input int idx);
      return (idx == 2) ? ov2 : ov1;
   endfunction

   task automatic start(input int idx, input logic [15:0] x, input logic [15:0] y0, input logic b);
      @(negedge clk);
      if (idx == 2) begin x2 = x; y02 = y0; byp2 = b; iv2 = 1'b1; end
      else          begin x1 = x; y01 = y0; byp1 = b; iv1 = 1'b1; end
      @(posedge clk);
      #1;
      if (idx == 2) begin iv2 = 1'b0; x2 = 16'hFFFF; y02 = 16'hFFFF; byp2 = 1'b1; end
      else          begin iv1 = 1'b0; x1 = 16'hFFFF; y01 = 16'hFFFF; byp1 = 1'b1; end
   endtask

   // cycles from the accept edge until out_valid is seen; -1 if it never rises
   task automatic wait_out(input int idx, output int l);
      l = -1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (ov(idx)) begin l = k; break; end
      end
   endtask

   task automatic ack(input int idx, input string tag);
      @(negedge clk);
      if (idx == 2) ordy2 = 1'b1; else ordy1 = 1'b1;
      @(posedge clk);
      #1;
      if (idx == 2) ordy2 = 1'b0; else ordy1 = 1'b0;
      chk({tag, "_ack_out_valid"}, 32'(ov(idx)), 0);
      chk({tag, "_ack_in_ready"}, (idx == 2) ? 32'(ir2) : 32'(ir1), 1);
   endtask

   initial begin
      rst = 1'b1;
      iv1 = 0; x1 = 0; y01 = 0; byp1 = 0; ordy1 = 0;
      iv2 = 0; x2 = 0; y02 = 0; byp2 = 0; ordy2 = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(ir1), 0);
      chk("rst_out_valid", 32'(ov1), 0);
      chk("rst_out_y", 32'(oy1), 32'h0000);
      chk("rst_in_ready2", 32'(ir2), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(ir1), 1);

      // 1/sqrt(4) from an exact guess stays exact
      start(1, 16'h4400, 16'h3800, 1'b0);
      wait_out(1, lat);
      chk("exact_latency", 32'(lat), 5);
      chk("exact_y", 32'(oy1), 32'h3800);
      ack(1, "exact");

      // 0.875 guess for 1/sqrt(1): 0.875*(1.5-0.3828125) = 1001/1024
      start(1, 16'h3C00, 16'h3B00, 1'b0);
      wait_out(1, lat);
      chk("refine_latency", 32'(lat), 5);
      chk("refine_y", 32'(oy1), 32'h3BD2);
      ack(1, "refine");

      start(1, 16'h4000, 16'h7C00, 1'b1);
      wait_out(1, lat);
      chk("bypass_latency", 32'(lat), 1);
      chk("bypass_y", 32'(oy1), 32'h7C00);
      ack(1, "bypass");

      // backpressure, with a competing offer that must be ignored
      start(1, 16'h4C00, 16'h3400, 1'b0);
      wait_out(1, lat);
      chk("bp_latency", 32'(lat), 5);
      iv1 = 1'b1; x1 = 16'h4400; y01 = 16'h3C00; byp1 = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         chk("bp_out_valid", 32'(ov1), 1);
         chk("bp_out_y", 32'(oy1), 32'h3400);
         chk("bp_in_ready", 32'(ir1), 0);
      end
      iv1 = 1'b0;
      ack(1, "bp");

      // reset while in TERM
      start(1, 16'h4400, 16'h3800, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_in_ready_low", 32'(ir1), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("midrst_in_ready", 32'(ir1), 1);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (ov1) bad++;
      end
      chk("midrst_no_output", 32'(bad), 0);
      start(1, 16'h4400, 16'h3800, 1'b0);
      wait_out(1, lat);
      chk("after_rst_latency", 32'(lat), 5);
      chk("after_rst_y", 32'(oy1), 32'h3800);
      ack(1, "after_rst");

      // two passes: second pass 1001/1024 -> 2047/2048
      start(2, 16'h3C00, 16'h3B00, 1'b0);
`ifdef FP16_INVSQRT_NR_PERF_EN
      chk("it2_busy", 32'(bz2), 1);
`endif
      wait_out(2, lat);
      chk("it2_latency", 32'(lat), 9);
      chk("it2_y", 32'(oy2), 32'h3BFF);
      ack(2, "it2");
`ifdef FP16_INVSQRT_NR_PERF_EN
      chk("it2_perf_count", 32'(pc2), 1);
      chk("it2_busy_idle", 32'(bz2), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
